mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory request for loads/stores,
// stalls upstream while memory is not ready, and registers the MEM/WB outputs.
// Optional macro MEM_STAGE_TIMEOUT_EN adds a BUSY timeout that aborts the
// access, loads a bubble and sets the sticky mem_err flag.
//
// state | meaning
// IDLE  | no access outstanding; a new access may issue (and finish) this cycle
// BUSY  | access issued, still waiting for dmem_ready
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_MemToReg_in,
    input  logic        wb_RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] ALURes_in,
    input  logic [31:0] D2_in,
    input  logic [4:0]  RegDest_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        wb_MemToReg_out,
    output logic        wb_RegWrite_out,
    output logic [31:0] MemData_out,
    output logic [31:0] ALURes_out,
    output logic [4:0]  RegDest_out,
    output logic        mem_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q, state_d;
    logic   access;
    logic   is_read;
    logic   abort;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
    end

    // A simultaneous read and write request is handled as a store.
    assign access     = MemRead_in | MemWrite_in;
    assign is_read    = MemRead_in & ~MemWrite_in;
    assign dmem_addr  = ALURes_in;
    assign dmem_wdata = D2_in;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q;

    assign abort   = (state_q == BUSY) && !dmem_ready &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign mem_err = mem_err_q;

    // Wait counter: counts unready BUSY cycles, cleared whenever we return to IDLE.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (state_q == BUSY && !dmem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (abort) begin
                mem_err_q <= 1'b1;
            end
        end
    end
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Next-state, memory request and stall decode.
    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        stall    = access && !dmem_ready && !abort;
        case (state_q)
            IDLE: begin
                if (access) begin
                    dmem_req = 1'b1;
                    dmem_we  = MemWrite_in;
                    if (!dmem_ready) begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                dmem_req = 1'b1;
                dmem_we  = MemWrite_in;
                if (dmem_ready || abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM/WB register: load on progress, bubble while stalled or on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_MemToReg_out <= 1'b0;
            wb_RegWrite_out <= 1'b0;
            MemData_out     <= '0;
            ALURes_out      <= '0;
            RegDest_out     <= '0;
        end else if (stall || abort) begin
            wb_MemToReg_out <= 1'b0;
            wb_RegWrite_out <= 1'b0;
        end else begin
            wb_MemToReg_out <= wb_MemToReg_in;
            wb_RegWrite_out <= wb_RegWrite_in;
            ALURes_out      <= ALURes_in;
            RegDest_out     <= RegDest_in;
            if (is_read && dmem_ready) begin
                MemData_out <= dmem_rdata;
            end
        end
    end

endmodule
